alarm_trigger: RTL

ALARM_TRIGGER -- requirements
Module: alarm_trigger

---
 rtl/alarm_trigger.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alarm_trigger.sv
// Alarm trigger: watches the running time against the stored alarm setting
// and sequences IDLE -> RINGING -> SNOOZE with a 1 Hz buzzer, ring timeout,
// snooze timer and a per-event snooze limit. All outputs are registered.
module alarm_trigger #(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SEC   = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clock,
    input  logic       reset_alarm,
    input  logic       sec_tick,
    input  logic [5:0] count_hour,
    input  logic [5:0] count_min,
    input  logic [5:0] count_sec,
    input  logic [5:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_enable,
    input  logic       setting_alarm,
    input  logic       stop_alarm,
    input  logic       snooze_alarm,
    output logic       ringing,
    output logic       buzzer,
    output logic       snoozing,
    output logic [1:0] snooze_count
);

    // Counter widths; a 1-second timeout still needs a 1-bit counter.
    localparam int RW = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT) : 1;
    localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;

    localparam logic [RW-1:0] RING_LAST   = RW'(RING_TIMEOUT - 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);
    localparam logic [RW-1:0] RING_ONE    = RW'(1);
    localparam logic [SW-1:0] SNOOZE_ONE  = SW'(1);
    localparam logic [1:0]    SNOOZE_MAX  = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_match_q;
    logic            r_stop_q;
    logic            r_snooze_q;

    logic [RW-1:0]   r_ring_cnt;
    logic [RW-1:0]   w_ring_cnt_next;
    logic [SW-1:0]   r_snooze_cnt;
    logic [SW-1:0]   w_snooze_cnt_next;
    logic            r_buzzer;
    logic            w_buzzer_next;
    logic [1:0]      r_snooze_count;
    logic [1:0]      w_snooze_count_next;
    logic            r_ringing;
    logic            r_snoozing;

    logic            w_match;
    logic            w_trigger;
    logic            w_stop_edge;
    logic            w_snooze_edge;
    logic            w_can_snooze;
    logic            w_ring_last;
    logic            w_snooze_last;

    // Time comparison: only the first second of the alarm minute matches,
    // and editing the alarm masks it so a half-typed value cannot fire.
    assign w_match = alarm_enable & ~setting_alarm &
                     (count_hour == alarm_hour) &
                     (count_min == alarm_min) &
                     (count_sec == 6'd0);

    // One trigger per matching minute: the match register starts at 1 so a
    // reset released inside the matching second does not ring.
    assign w_trigger     = w_match & ~r_match_q;
    assign w_stop_edge   = stop_alarm & ~r_stop_q;
    assign w_snooze_edge = snooze_alarm & ~r_snooze_q;
    assign w_can_snooze  = (r_snooze_count < SNOOZE_MAX);
    assign w_ring_last   = (r_ring_cnt == RING_LAST);
    assign w_snooze_last = (r_snooze_cnt == SNOOZE_LAST);

    // State register plus registered datapath and outputs.
    always_ff @(posedge clock or posedge reset_alarm) begin
        if (reset_alarm) begin
            r_state        <= ST_IDLE;
            r_match_q      <= 1'b1;
            r_stop_q       <= 1'b1;
            r_snooze_q     <= 1'b1;
            r_ring_cnt     <= '0;
            r_snooze_cnt   <= '0;
            r_buzzer       <= 1'b0;
            r_snooze_count <= 2'd0;
            r_ringing      <= 1'b0;
            r_snoozing     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_match_q      <= w_match;
            r_stop_q       <= stop_alarm;
            r_snooze_q     <= snooze_alarm;
            r_ring_cnt     <= w_ring_cnt_next;
            r_snooze_cnt   <= w_snooze_cnt_next;
            r_buzzer       <= w_buzzer_next;
            r_snooze_count <= w_snooze_count_next;
            r_ringing      <= (w_state_next == ST_RINGING);
            r_snoozing     <= (w_state_next == ST_SNOOZE);
        end
    end

    // Next-state selection; disarming the alarm overrides every other event.
    always_comb begin
        w_state_next = r_state;
        if (!alarm_enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger)
                        w_state_next = ST_RINGING;
                end
                ST_RINGING: begin
                    if (w_stop_edge)
                        w_state_next = ST_IDLE;
                    else if (w_snooze_edge && w_can_snooze)
                        w_state_next = ST_SNOOZE;
                    else if (sec_tick && w_ring_last)
                        w_state_next = ST_IDLE;
                end
                ST_SNOOZE: begin
                    if (w_stop_edge)
                        w_state_next = ST_IDLE;
                    else if (sec_tick && w_snooze_last)
                        w_state_next = ST_RINGING;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Counter, snooze tally and buzzer updates, mirroring the transition priority.
    always_comb begin
        w_ring_cnt_next     = r_ring_cnt;
        w_snooze_cnt_next   = r_snooze_cnt;
        w_buzzer_next       = r_buzzer;
        w_snooze_count_next = r_snooze_count;
        if (!alarm_enable) begin
            w_buzzer_next = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_buzzer_next = 1'b0;
                    if (w_trigger) begin
                        w_ring_cnt_next     = '0;
                        w_snooze_count_next = 2'd0;
                        w_buzzer_next       = 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (w_stop_edge) begin
                        w_buzzer_next = 1'b0;
                    end else if (w_snooze_edge && w_can_snooze) begin
                        w_snooze_cnt_next   = '0;
                        w_snooze_count_next = r_snooze_count + 2'd1;
                        w_buzzer_next       = 1'b0;
                    end else if (sec_tick) begin
                        if (w_ring_last) begin
                            w_buzzer_next = 1'b0;
                        end else begin
                            w_ring_cnt_next = r_ring_cnt + RING_ONE;
                            w_buzzer_next   = ~r_buzzer;
                        end
                    end
                end
                ST_SNOOZE: begin
                    w_buzzer_next = 1'b0;
                    if (!w_stop_edge && sec_tick) begin
                        if (w_snooze_last) begin
                            w_ring_cnt_next = '0;
                            w_buzzer_next   = 1'b1;
                        end else begin
                            w_snooze_cnt_next = r_snooze_cnt + SNOOZE_ONE;
                        end
                    end
                end
                default: w_buzzer_next = 1'b0;
            endcase
        end
    end

    assign ringing      = r_ringing;
    assign buzzer       = r_buzzer;
    assign snoozing     = r_snoozing;
    assign snooze_count = r_snooze_count;

endmodule
